// File: rtl/crc_sequencer.sv
// Byte-serial CRC sequencer: captures a polynomial configuration, loads an external
// LFSR and feeds it one bit per cycle from a valid/ready byte stream.
module crc_sequencer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [5:0]       cfg_bitwidth,
    input  logic [WIDTH-1:0] cfg_taps,
    input  logic [WIDTH-1:0] cfg_init,
    input  logic             cfg_lsb_first,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             lfsr_load,
    output logic             lfsr_shift,
    output logic             lfsr_data,
    output logic [5:0]       lfsr_bitwidth,
    output logic [WIDTH-1:0] lfsr_taps,
    output logic [WIDTH-1:0] lfsr_init,
    input  logic [WIDTH-1:0] lfsr_value,
    output logic             crc_valid,
    output logic [WIDTH-1:0] crc_out,
    output logic             busy
);

    localparam int unsigned BW_W  = 6;
    localparam int unsigned SH_W  = BW_W + 1;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCEPT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         byte_q;
    logic               last_q;
    logic               lsb_first_q;
    logic [CNT_W-1:0]   cnt;
    logic               data_next_c;
    logic [WIDTH-1:0]   mask_c;
    logic [WIDTH-1:0]   crc_hold;

    function automatic logic pick_bit(input logic [7:0] b, input logic [CNT_W-1:0] idx,
                                      input logic lsb);
        return lsb ? b[idx] : b[3'd7 - idx];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic and the serial bit to present in the following cycle
    always_comb begin
        state_next  = state;
        data_next_c = 1'b0;
        case (state)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD:   state_next = S_ACCEPT;
            S_ACCEPT: begin
                if (in_valid) begin
                    state_next  = S_SHIFT;
                    data_next_c = pick_bit(in_data, CNT_W'(0), lsb_first_q);
                end
            end
            S_SHIFT: begin
                if (cnt == CNT_W'(7)) begin
                    state_next = last_q ? S_DONE : S_ACCEPT;
                end else begin
                    data_next_c = pick_bit(byte_q, CNT_W'(cnt + CNT_W'(1)), lsb_first_q);
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Low (bitwidth+1) bits set; a shift of WIDTH or more yields zero, i.e. a full mask
    assign mask_c = ~({WIDTH{1'b1}} << (SH_W'(lfsr_bitwidth) + SH_W'(1)));

    // Result follows the LFSR during DONE so the final shift is included, then holds
    assign crc_out = (state == S_DONE) ? (lfsr_value & mask_c) : crc_hold;

    // Config, byte capture, bit counter and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_bitwidth <= BW_W'(31);
            lfsr_taps     <= WIDTH'(32'h04C1_1DB7);
            lfsr_init     <= WIDTH'(32'hFFFF_FFFF);
            lsb_first_q   <= 1'b0;
            byte_q        <= 8'd0;
            last_q        <= 1'b0;
            cnt           <= CNT_W'(0);
            in_ready      <= 1'b0;
            lfsr_load     <= 1'b0;
            lfsr_shift    <= 1'b0;
            lfsr_data     <= 1'b0;
            crc_valid     <= 1'b0;
            busy          <= 1'b0;
            crc_hold      <= '0;
        end else begin
            if (state == S_IDLE && cfg_we) begin
                lfsr_bitwidth <= cfg_bitwidth;
                lfsr_taps     <= cfg_taps;
                lfsr_init     <= cfg_init;
                lsb_first_q   <= cfg_lsb_first;
            end
            if (state == S_ACCEPT && in_valid) begin
                byte_q <= in_data;
                last_q <= in_last;
                cnt    <= CNT_W'(0);
            end else if (state == S_SHIFT) begin
                cnt <= CNT_W'(cnt + CNT_W'(1));
            end
            if (state == S_DONE) crc_hold <= lfsr_value & mask_c;
            in_ready   <= (state_next == S_ACCEPT);
            lfsr_load  <= (state_next == S_LOAD);
            lfsr_shift <= (state_next == S_SHIFT);
            crc_valid  <= (state_next == S_DONE);
            busy       <= (state_next != S_IDLE);
            lfsr_data  <= data_next_c;
        end
    end

endmodule
